// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bus: decoded instruction fields into the scoreboard,
// pipeline control, busy bitmap and stall statistics back out.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 4,
  parameter int LAT_W      = $clog2(MAX_LAT + 1),
  parameter int CNT_W      = 16
);
  logic                       IDValid_i;
  logic                       Flush_i;
  logic [REG_ADDR_W-1:0]      RS1addr_i;
  logic [REG_ADDR_W-1:0]      RS2addr_i;
  logic                       RS1use_i;
  logic                       RS2use_i;
  logic [REG_ADDR_W-1:0]      Rd_i;
  logic                       RegWrite_i;
  logic [LAT_W-1:0]           Lat_i;
  logic                       PCWrite_o;
  logic                       Stall_o;
  logic                       NoOp_o;
  logic [2**REG_ADDR_W-1:0]   Busy_o;
  logic [CNT_W-1:0]           StallCnt_o;

  modport master (
    output IDValid_i, Flush_i, RS1addr_i, RS2addr_i, RS1use_i, RS2use_i,
           Rd_i, RegWrite_i, Lat_i,
    input  PCWrite_o, Stall_o, NoOp_o, Busy_o, StallCnt_o
  );

  modport slave (
    input  IDValid_i, Flush_i, RS1addr_i, RS2addr_i, RS1use_i, RS2use_i,
           Rd_i, RegWrite_i, Lat_i,
    output PCWrite_o, Stall_o, NoOp_o, Busy_o, StallCnt_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for the ID stage: stalls on RAW/WAW against
// in-flight multi-cycle producers and counts stall cycles.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 4,
  parameter int LAT_W      = $clog2(MAX_LAT + 1),
  parameter int CNT_W      = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  hazard_scoreboard_if.slave bus
);
  localparam int              NREG      = 2**REG_ADDR_W;
  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0] cnt [NREG];
  logic [LAT_W-1:0] lat_clamped;
  logic             raw, waw, hazard, issue, record;
  logic [CNT_W-1:0] stall_cnt;

  // NOTE: every signal gets a value on every path so no latch is inferred.
  always_comb begin
    lat_clamped = (bus.Lat_i > MAX_LAT_V) ? MAX_LAT_V : bus.Lat_i;
    raw = (bus.RS1use_i && (bus.RS1addr_i != '0) && (cnt[bus.RS1addr_i] != '0)) ||
          (bus.RS2use_i && (bus.RS2addr_i != '0) && (cnt[bus.RS2addr_i] != '0));
    // A younger writer may only issue once the older one retires no later than it.
    waw = bus.RegWrite_i && (bus.Rd_i != '0) && (cnt[bus.Rd_i] > lat_clamped);
    hazard = bus.IDValid_i && !bus.Flush_i && (raw || waw);
    issue  = bus.IDValid_i && !bus.Flush_i && !hazard;
    record = issue && bus.RegWrite_i && (bus.Rd_i != '0);
  end

  // NOTE: state uses non-blocking assignments so all entries update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the counter array is reset because stale countdowns would cause false stalls.
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (record && (bus.Rd_i == REG_ADDR_W'(r))) begin
          cnt[r] <= lat_clamped;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.PCWrite_o  = !hazard;
    bus.Stall_o    = hazard;
    bus.NoOp_o     = hazard;
    bus.Busy_o     = '0;
    bus.StallCnt_o = stall_cnt;
    if (rst_i) begin
      bus.PCWrite_o = 1'b0;
      bus.Stall_o   = 1'b1;
      bus.NoOp_o    = 1'b1;
    end else begin
      for (int r = 1; r < NREG; r++) bus.Busy_o[r] = (cnt[r] != '0);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed latency scenarios plus
// randomized traffic against a ready-time reference model.
module tb_hazard_scoreboard;
  localparam int RA   = 5;
  localparam int ML   = 4;
  localparam int LW   = $clog2(ML + 1);
  localparam int CW   = 16;
  localparam int NREG = 2**RA;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  hazard_scoreboard_if #(.REG_ADDR_W(RA), .MAX_LAT(ML), .LAT_W(LW), .CNT_W(CW)) bus ();

  hazard_scoreboard #(.REG_ADDR_W(RA), .MAX_LAT(ML), .LAT_W(LW), .CNT_W(CW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: each register becomes forwardable at an absolute cycle number.
  int              ready_at [NREG];
  int              cyc         = 0;
  int              m_stall_cnt = 0;
  logic            m_hazard, m_issue;
  logic            exp_pcw, exp_stall, exp_noop;
  logic [NREG-1:0] exp_busy;

  function automatic int rem(int r);
    if (r == 0) return 0;
    return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
  endfunction

  function automatic int clamp_lat(int l);
    return (l > ML) ? ML : l;
  endfunction

  task automatic model_eval();
    bit raw, waw;
    int l;
    l   = clamp_lat(int'(bus.Lat_i));
    raw = (bus.RS1use_i && rem(int'(bus.RS1addr_i)) > 0) ||
          (bus.RS2use_i && rem(int'(bus.RS2addr_i)) > 0);
    waw = bus.RegWrite_i && rem(int'(bus.Rd_i)) > l;
    m_hazard = bus.IDValid_i && !bus.Flush_i && (raw || waw);
    m_issue  = bus.IDValid_i && !bus.Flush_i && !m_hazard;
    exp_busy = '0;
    for (int r = 0; r < NREG; r++) exp_busy[r] = (rem(r) > 0);
    if (rst_i) begin
      exp_pcw = 1'b0; exp_stall = 1'b1; exp_noop = 1'b1; exp_busy = '0;
    end else begin
      exp_pcw = !m_hazard; exp_stall = m_hazard; exp_noop = m_hazard;
    end
  endtask

  task automatic model_commit();
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      m_stall_cnt = 0;
    end else begin
      if (m_hazard && m_stall_cnt < 2**CW - 1) m_stall_cnt++;
      if (m_issue && bus.RegWrite_i && bus.Rd_i != '0)
        ready_at[bus.Rd_i] = cyc + 1 + clamp_lat(int'(bus.Lat_i));
    end
  endtask

  task automatic tick();
    model_eval();
    model_commit();
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic drive(int v, int f, int s1, int u1, int s2, int u2, int rd, int we, int lat);
    bus.IDValid_i  = v[0];
    bus.Flush_i    = f[0];
    bus.RS1addr_i  = RA'(s1);
    bus.RS1use_i   = u1[0];
    bus.RS2addr_i  = RA'(s2);
    bus.RS2use_i   = u2[0];
    bus.Rd_i       = RA'(rd);
    bus.RegWrite_i = we[0];
    bus.Lat_i      = LW'(lat);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_issue(input int max, output int n);
    n = 0;
    while (bus.Stall_o === 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle();
    tick();
    tick();
    compared += 5;
    if (bus.PCWrite_o !== 1'b0) begin mismatched++; $display("FAIL reset_pcwrite: got %b want 0", bus.PCWrite_o); end
    if (bus.Stall_o !== 1'b1) begin mismatched++; $display("FAIL reset_stall: got %b want 1", bus.Stall_o); end
    if (bus.NoOp_o !== 1'b1) begin mismatched++; $display("FAIL reset_noop: got %b want 1", bus.NoOp_o); end
    if (bus.Busy_o !== '0) begin mismatched++; $display("FAIL reset_busy: got %h want 0", bus.Busy_o); end
    if (bus.StallCnt_o !== '0) begin mismatched++; $display("FAIL reset_stallcnt: got %0d want 0", bus.StallCnt_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_load_use();
    int n;
    drive(1, 0, 0, 0, 0, 0, 5, 1, 1);
    compared++;
    if (bus.Stall_o !== 1'b0) begin mismatched++; $display("FAIL loaduse_producer: stall got %b want 0", bus.Stall_o); end
    tick();
    drive(1, 0, 5, 1, 0, 0, 0, 0, 0);
    compared += 3;
    if (bus.Stall_o !== 1'b1) begin mismatched++; $display("FAIL loaduse_stall: got %b want 1", bus.Stall_o); end
    if (bus.NoOp_o !== 1'b1) begin mismatched++; $display("FAIL loaduse_noop: got %b want 1", bus.NoOp_o); end
    if (bus.PCWrite_o !== 1'b0) begin mismatched++; $display("FAIL loaduse_pcwrite: got %b want 0", bus.PCWrite_o); end
    wait_issue(4, n);
    compared += 2;
    if (n != 1) begin mismatched++; $display("FAIL loaduse_stall_cycles: got %0d want 1", n); end
    if (bus.StallCnt_o !== 16'd1) begin mismatched++; $display("FAIL loaduse_stallcnt: got %0d want 1", bus.StallCnt_o); end
    tick();
    idle();
  endtask

  task automatic test_multicycle();
    int n;
    drive(1, 0, 0, 0, 0, 0, 7, 1, 3);
    tick();
    drive(1, 0, 0, 0, 7, 1, 0, 0, 0);
    n = 0;
    while (bus.Stall_o === 1'b1 && n < 6) begin
      compared++;
      if (bus.Busy_o[7] !== 1'b1) begin mismatched++; $display("FAIL multi_busy_during: cycle %0d got %b want 1", n, bus.Busy_o[7]); end
      tick();
      n++;
    end
    compared += 2;
    if (n != 3) begin mismatched++; $display("FAIL multi_stall_cycles: got %0d want 3", n); end
    if (bus.Busy_o[7] !== 1'b0) begin mismatched++; $display("FAIL multi_busy_after: got %b want 0", bus.Busy_o[7]); end
    tick();
    idle();
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 4);
    compared++;
    if (bus.Stall_o !== 1'b0) begin mismatched++; $display("FAIL x0_producer: stall got %b want 0", bus.Stall_o); end
    tick();
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
    compared += 2;
    if (bus.Stall_o !== 1'b0) begin mismatched++; $display("FAIL x0_consumer: stall got %b want 0", bus.Stall_o); end
    if (bus.Busy_o !== '0) begin mismatched++; $display("FAIL x0_busy: got %h want 0", bus.Busy_o); end
    tick();
    idle();
  endtask

  task automatic test_waw();
    int n;
    drive(1, 0, 0, 0, 0, 0, 9, 1, 3);
    tick();
    drive(1, 0, 0, 0, 0, 0, 9, 1, 1);
    wait_issue(6, n);
    compared++;
    if (n != 2) begin mismatched++; $display("FAIL waw_stall_cycles: got %0d want 2", n); end
    tick();
    idle();
    compared++;
    if (bus.Busy_o[9] !== 1'b1) begin mismatched++; $display("FAIL waw_busy_reloaded: got %b want 1", bus.Busy_o[9]); end
    tick();
  endtask

  task automatic test_flush();
    int n;
    drive(1, 1, 0, 0, 0, 0, 11, 1, 2);
    compared++;
    if (bus.Stall_o !== 1'b0) begin mismatched++; $display("FAIL flush_producer: stall got %b want 0", bus.Stall_o); end
    tick();
    drive(1, 0, 11, 1, 0, 0, 0, 0, 0);
    compared += 2;
    if (bus.Stall_o !== 1'b0) begin mismatched++; $display("FAIL flush_not_recorded: stall got %b want 0", bus.Stall_o); end
    if (bus.Busy_o[11] !== 1'b0) begin mismatched++; $display("FAIL flush_busy: got %b want 0", bus.Busy_o[11]); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 12, 1, 2);
    tick();
    drive(1, 1, 12, 1, 0, 0, 0, 0, 0);
    compared++;
    if (bus.Stall_o !== 1'b0) begin mismatched++; $display("FAIL flush_suppresses_stall: got %b want 0", bus.Stall_o); end
    tick();
    drive(1, 0, 12, 1, 0, 0, 0, 0, 0);
    wait_issue(4, n);
    compared++;
    if (n != 1) begin mismatched++; $display("FAIL flush_decrement_continues: stalls got %0d want 1", n); end
    tick();
    idle();
  endtask

  task automatic test_clamp_reset();
    int n;
    drive(1, 0, 0, 0, 0, 0, 3, 1, 7);
    tick();
    drive(1, 0, 3, 1, 0, 0, 0, 0, 0);
    wait_issue(8, n);
    compared++;
    if (n != 4) begin mismatched++; $display("FAIL clamp_stall_cycles: got %0d want 4", n); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 3, 1, 7);
    tick();
    drive(1, 0, 3, 1, 0, 0, 0, 0, 0);
    tick();
    tick();
    compared++;
    if (bus.Stall_o !== 1'b1) begin mismatched++; $display("FAIL clamp_pending_stall: got %b want 1", bus.Stall_o); end
    rst_i = 1'b1;
    #1;
    compared += 2;
    if (bus.Busy_o !== '0) begin mismatched++; $display("FAIL rst_forces_busy: got %h want 0", bus.Busy_o); end
    if (bus.PCWrite_o !== 1'b0) begin mismatched++; $display("FAIL rst_forces_pcwrite: got %b want 0", bus.PCWrite_o); end
    tick();
    rst_i = 1'b0;
    #1;
    compared += 3;
    if (bus.Stall_o !== 1'b0) begin mismatched++; $display("FAIL midreset_no_stall: got %b want 0", bus.Stall_o); end
    if (bus.Busy_o !== '0) begin mismatched++; $display("FAIL midreset_busy: got %h want 0", bus.Busy_o); end
    if (bus.StallCnt_o !== '0) begin mismatched++; $display("FAIL midreset_stallcnt: got %0d want 0", bus.StallCnt_o); end
    tick();
    idle();
  endtask

  task automatic test_random();
    rst_i = 1'b1;
    idle();
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      drive(int'($urandom_range(0, 99) < 85), int'($urandom_range(0, 99) < 10),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)));
      model_eval();
      compared += 5;
      if (bus.PCWrite_o !== exp_pcw) begin mismatched++; $display("FAIL rand_pcwrite: iter %0d got %b want %b", i, bus.PCWrite_o, exp_pcw); end
      if (bus.Stall_o !== exp_stall) begin mismatched++; $display("FAIL rand_stall: iter %0d got %b want %b", i, bus.Stall_o, exp_stall); end
      if (bus.NoOp_o !== exp_noop) begin mismatched++; $display("FAIL rand_noop: iter %0d got %b want %b", i, bus.NoOp_o, exp_noop); end
      if (bus.Busy_o !== exp_busy) begin mismatched++; $display("FAIL rand_busy: iter %0d got %h want %h", i, bus.Busy_o, exp_busy); end
      if (bus.StallCnt_o !== CW'(m_stall_cnt)) begin mismatched++; $display("FAIL rand_stallcnt: iter %0d got %0d want %0d", i, bus.StallCnt_o, m_stall_cnt); end
      tick();
    end
    rst_i = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multicycle();
    test_x0();
    test_waw();
    test_flush();
    test_clamp_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
